march_bist_ctrl: RTL and testbench
==================================

# march_bist_ctrl

Parametrised memory BIST controller running a March C- algorithm over a synchronous single-port RAM of 2^ADDR_W words × DATA_W bits. It sequences reads and writes with an internal up/down address counter, compares read data against the expected background, and reports `done`, a sticky `fail`, and optionally the first failing address and element. It replaces the fixed-width counter/compare controller and sits between the BIST start/status register and the RAM wrapper's test port.

## Interface
- ADDR_W, 4, address width; DEPTH = 2^ADDR_W
- DATA_W, 8, data width; backgrounds are all-0 and all-1
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- start  in  1  level; begins a test when sampled high in IDLE
- mem_rdata  in  DATA_W  RAM read data, valid one cycle after a read request
- mem_en  out  1  RAM access strobe
- mem_we  out  1  1 = write, 0 = read (valid with mem_en)
- mem_addr  out  ADDR_W  RAM address
- mem_wdata  out  DATA_W  write data
- busy  out  1  high in RUN and DRAIN
- done  out  1  level; high in DONE
- fail  out  1  sticky mismatch flag
- fail_addr  out  ADDR_W  address of first mismatch (BIST_FAIL_LOG_EN only)
- fail_elem  out  3  march element of first mismatch (BIST_FAIL_LOG_EN only)

## Operation
- Elements: E0 ⇕(w0); E1 ⇑(r0,w1); E2 ⇑(r1,w0); E3 ⇓(r0,w1); E4 ⇓(r1,w0); E5 ⇕(r0). ⇕ runs ascending.
- ⇑ addresses 0→DEPTH-1; ⇓ addresses DEPTH-1→0. Counter reloads at each element boundary (0 or DEPTH-1); no gap cycle between elements.
- One op per cycle; r/w pair at one address issues read at t, write at t+1, same address.
- FSM: IDLE → RUN (start high) → DRAIN (after last E5 read, 1 cycle) → DONE → IDLE (only once start low).
- Compare: one cycle after each read, mem_rdata vs expected (0 or all-ones); mismatch sets fail on the next edge. fail never clears except on rst or new start.
- Test always runs to completion; no abort on fail.
- Start from IDLE clears fail, fail_addr, fail_elem.
- Start held high through DONE does not restart; a low phase is required.

## Timing
- Reset values: mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, fail=0, fail_addr=0, fail_elem=0; state IDLE. Reset mid-run aborts immediately, no further RAM access.
- Cycle 0 = edge sampling start in IDLE. Ops occupy cycles 1..10·DEPTH (E0 and E5: DEPTH each; E1–E4: 2·DEPTH each).
- DRAIN at cycle 10·DEPTH+1 (final compare); done high from cycle 10·DEPTH+2. DEPTH=16: 160 ops, done at cycle 162.
- mem_* outputs registered; mem_en low in IDLE, DRAIN, DONE.
- Mismatch on read issued at cycle t: fail high from cycle t+2.

## Configuration
- BIST_FAIL_LOG_EN defined: fail_addr/fail_elem capture the address and element of the first mismatch only; later mismatches do not overwrite.
- Undefined: no capture registers; fail_addr and fail_elem tied to 0; fail behaviour unchanged.

## Structure
- Package bist_pkg: FSM state encoding (IDLE, RUN, DRAIN, DONE), element encoding E0–E5, NUM_ELEM=6, per-element direction/op-sequence/expected-data constants.
- Sub-module bist_addr_counter: ADDR_W-bit up/down counter with load-to-0 / load-to-max, enable, and terminal-count output for the element's direction.

## Test plan
- Fault-free RAM model, ADDR_W=4, DATA_W=8, start high at cycle 0 → 160 ops in March C- order, done high at cycle 162, fail=0.
- Bit 3 stuck-at-0 at address 5 → fail=1; with BIST_FAIL_LOG_EN fail_addr=5, fail_elem=2; done still at cycle 162.
- Check ⇓ elements: first E3 access is read at address 15, last E4 access is write at address 0.
- rst low at cycle 50 → all outputs 0 asynchronously; next start after release reruns full 160 ops.
- Start held high after done → stays in DONE with done=1; start low then high → fail cleared, new run begins.
- Two faults (address 2 E1 mismatch, address 9 E4 mismatch) → fail_addr=2, fail_elem=1, not overwritten.

Source files
------------

// File: rtl/bist_pkg.sv
// Shared encodings for the March C- BIST controller:
// FSM states, march elements and per-element sequencing constants.
package bist_pkg;

    localparam int NUM_ELEM = 6;
    localparam int ELEM_W   = 3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_e;

    typedef enum logic [ELEM_W-1:0] {
        ELEM_E0,
        ELEM_E1,
        ELEM_E2,
        ELEM_E3,
        ELEM_E4,
        ELEM_E5
    } elem_e;

    // op1, when present, is always a write
    typedef struct packed {
        logic down;
        logic two_op;
        logic op0_we;
        logic op0_bg;
        logic op1_bg;
    } elem_cfg_t;

    function automatic elem_cfg_t elem_cfg(input elem_e e);
        elem_cfg_t c;
        c = '0;
        unique case (e)
            ELEM_E0: c = '{down: 1'b0, two_op: 1'b0, op0_we: 1'b1,
                           op0_bg: 1'b0, op1_bg: 1'b0};
            ELEM_E1: c = '{down: 1'b0, two_op: 1'b1, op0_we: 1'b0,
                           op0_bg: 1'b0, op1_bg: 1'b1};
            ELEM_E2: c = '{down: 1'b0, two_op: 1'b1, op0_we: 1'b0,
                           op0_bg: 1'b1, op1_bg: 1'b0};
            ELEM_E3: c = '{down: 1'b1, two_op: 1'b1, op0_we: 1'b0,
                           op0_bg: 1'b0, op1_bg: 1'b1};
            ELEM_E4: c = '{down: 1'b1, two_op: 1'b1, op0_we: 1'b0,
                           op0_bg: 1'b1, op1_bg: 1'b0};
            ELEM_E5: c = '{down: 1'b0, two_op: 1'b0, op0_we: 1'b0,
                           op0_bg: 1'b0, op1_bg: 1'b0};
            default: c = '0;
        endcase
        return c;
    endfunction

    function automatic elem_e elem_next(input elem_e e);
        elem_e n;
        n = ELEM_E0;
        unique case (e)
            ELEM_E0: n = ELEM_E1;
            ELEM_E1: n = ELEM_E2;
            ELEM_E2: n = ELEM_E3;
            ELEM_E3: n = ELEM_E4;
            ELEM_E4: n = ELEM_E5;
            ELEM_E5: n = ELEM_E5;
            default: n = ELEM_E0;
        endcase
        return n;
    endfunction

    function automatic logic elem_down(input elem_e e);
        elem_cfg_t c;
        c = elem_cfg(e);
        return c.down;
    endfunction

endpackage

// File: rtl/bist_addr_counter.sv
// Up/down march address counter with load-to-0/load-to-max
// and a direction-aware terminal count.
module bist_addr_counter #(
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              load_max,
    input  logic              en,
    input  logic              down,
    output logic [ADDR_W-1:0] cnt,
    output logic              tc
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_max ? '1 : '0;
        end else if (en) begin
            cnt <= down ? cnt - 1'b1 : cnt + 1'b1;
        end
    end

    assign tc = down ? (cnt == '0) : (cnt == '1);

endmodule

// File: rtl/march_bist_ctrl.sv
// March C- memory BIST sequencer and read comparator.
// Define BIST_FAIL_LOG_EN to capture first-failure address/element.
module march_bist_ctrl
    import bist_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              fail,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [2:0]        fail_elem
);

    state_e            state_q;
    state_e            state_d;
    elem_e             elem_q;
    logic              phase_q;
    logic              fin_q;
    elem_cfg_t         cfg;
    logic              nx_down;

    logic [ADDR_W-1:0] cnt;
    logic              tc;
    logic              cnt_load;
    logic              cnt_load_max;
    logic              cnt_en;

    logic              start_ev;
    logic              step;
    logic              addr_last;
    logic              elem_end;
    logic              op_we;
    logic              op_bg;

    logic              chk_vld;
    logic [DATA_W-1:0] chk_exp;
    logic              mismatch;

    assign cfg       = elem_cfg(elem_q);
    assign nx_down   = elem_down(elem_next(elem_q));

    assign start_ev  = (state_q == ST_IDLE) && start;
    assign step      = (state_q == ST_RUN) && !fin_q;
    assign addr_last = !cfg.two_op || phase_q;
    assign elem_end  = step && addr_last && tc;

    assign op_we     = phase_q ? 1'b1 : cfg.op0_we;
    assign op_bg     = phase_q ? cfg.op1_bg : cfg.op0_bg;

    assign cnt_load     = start_ev ||
                          (elem_end && elem_q != ELEM_E5);
    assign cnt_load_max = start_ev ? 1'b0 : nx_down;
    assign cnt_en       = step && addr_last && !tc;

    bist_addr_counter #(
        .ADDR_W (ADDR_W)
    ) u_cnt (
        .clk      (clk),
        .rst_n    (rst),
        .load     (cnt_load),
        .load_max (cnt_load_max),
        .en       (cnt_en),
        .down     (cfg.down),
        .cnt      (cnt),
        .tc       (tc)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (start) state_d = ST_RUN;
            ST_RUN:   if (fin_q) state_d = ST_DRAIN;
            ST_DRAIN: state_d = ST_DONE;
            ST_DONE:  if (!start) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        unique case (state_q)
            ST_RUN:   busy = 1'b1;
            ST_DRAIN: busy = 1'b1;
            ST_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    // fin_q marks that the final E5 read has been issued
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            elem_q  <= ELEM_E0;
            phase_q <= 1'b0;
            fin_q   <= 1'b0;
        end else if (start_ev) begin
            elem_q  <= ELEM_E0;
            phase_q <= 1'b0;
            fin_q   <= 1'b0;
        end else if (step) begin
            phase_q <= !addr_last;
            if (elem_end) begin
                if (elem_q == ELEM_E5) begin
                    fin_q <= 1'b1;
                end else begin
                    elem_q <= elem_next(elem_q);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else if (step) begin
            mem_en    <= 1'b1;
            mem_we    <= op_we;
            mem_addr  <= cnt;
            mem_wdata <= {DATA_W{op_bg}};
        end else begin
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
        end
    end

    // On reads mem_wdata carries the expected background
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            chk_vld <= 1'b0;
            chk_exp <= '0;
        end else begin
            chk_vld <= !start_ev && mem_en && !mem_we;
            chk_exp <= mem_wdata;
        end
    end

    assign mismatch = chk_vld && (mem_rdata != chk_exp);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fail <= 1'b0;
        end else if (start_ev) begin
            fail <= 1'b0;
        end else if (mismatch) begin
            fail <= 1'b1;
        end
    end

`ifdef BIST_FAIL_LOG_EN
    elem_e             mem_elem_q;
    logic [ADDR_W-1:0] chk_addr;
    elem_e             chk_elem;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_elem_q <= ELEM_E0;
            chk_addr   <= '0;
            chk_elem   <= ELEM_E0;
        end else begin
            if (step) mem_elem_q <= elem_q;
            chk_addr <= mem_addr;
            chk_elem <= mem_elem_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fail_addr <= '0;
            fail_elem <= '0;
        end else if (start_ev) begin
            fail_addr <= '0;
            fail_elem <= '0;
        end else if (mismatch && !fail) begin
            fail_addr <= chk_addr;
            fail_elem <= chk_elem;
        end
    end
`else
    assign fail_addr = '0;
    assign fail_elem = '0;
`endif

endmodule

// File: tb/tb_march_bist_ctrl.sv
// Scoreboard bench for march_bist_ctrl: a RAM model with injectable
// faults, an expected-op queue, and a negedge monitor that pops it.
module tb_march_bist_ctrl;

    localparam int AW    = 4;
    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int NOPS  = 160;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } op_t;

    logic          clk;
    logic          rst;
    logic          start;
    logic [DW-1:0] mem_rdata;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          busy;
    logic          done;
    logic          fail;
    logic [AW-1:0] fail_addr;
    logic [2:0]    fail_elem;

    int tests  = 0;
    int failed = 0;

    op_t exp_q[$];
    op_t obs[NOPS];
    int  obs_idx;

    string march [6] = '{"w0", "r0w1", "r1w0", "r0w1", "r1w0", "r0"};
    string dirs      = "UUUDDU";

    logic [DW-1:0] ram [DEPTH];
    int            ram_ops;
    int            sa_addr = -1;
    logic [DW-1:0] sa_mask = 8'h08;
    int            cr_addr [2] = '{-1, -1};
    int            cr_lo   [2] = '{0, 0};
    int            cr_hi   [2] = '{0, 0};

    march_bist_ctrl #(
        .ADDR_W (AW),
        .DATA_W (DW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .mem_rdata (mem_rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .busy      (busy),
        .done      (done),
        .fail      (fail),
        .fail_addr (fail_addr),
        .fail_elem (fail_elem)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DW-1:0] rd_val(input int a, input int idx);
        logic [DW-1:0] v;
        v = ram[a];
        if (a == sa_addr) v = v & ~sa_mask;
        for (int i = 0; i < 2; i++) begin
            if (a == cr_addr[i] && idx >= cr_lo[i] && idx <= cr_hi[i])
                v = v ^ 8'h01;
        end
        return v;
    endfunction

    always @(posedge clk) begin
        if (!rst || done) ram_ops <= 0;
        else if (mem_en) ram_ops <= ram_ops + 1;
        if (mem_en) begin
            if (mem_we) begin
                if (int'(mem_addr) == sa_addr)
                    ram[mem_addr] <= mem_wdata & ~sa_mask;
                else
                    ram[mem_addr] <= mem_wdata;
            end else begin
                mem_rdata <= rd_val(int'(mem_addr), ram_ops);
            end
        end
    end

    task automatic push_ops(input int n);
        int  k;
        int  a;
        string s;
        op_t o;
        k = 0;
        for (int e = 0; e < 6; e++) begin
            s = march[e];
            for (int i = 0; i < DEPTH; i++) begin
                a = (dirs[e] == "D") ? DEPTH - 1 - i : i;
                for (int j = 0; j < s.len(); j += 2) begin
                    o.we   = (s[j] == "w");
                    o.addr = a[AW-1:0];
                    o.data = {DW{s[j+1] == "1"}};
                    if (k < n) exp_q.push_back(o);
                    k++;
                end
            end
        end
    endtask

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] want);
        tests++;
        if (act !== want) begin
            failed++;
            $display("FAIL %s: got %0h, want %0h", name, act, want);
        end
    endtask

    // Scoreboard monitor: pops one expected op per observed RAM access
    initial begin
        op_t o;
        op_t e;
        logic bad;
        obs_idx = 0;
        forever begin
            @(negedge clk);
            if (!rst || done) begin
                obs_idx = 0;
            end else if (mem_en) begin
                o = {mem_we, mem_addr, mem_wdata};
                if (obs_idx < NOPS) obs[obs_idx] = o;
                tests++;
                if (exp_q.size() == 0) begin
                    failed++;
                    $display("FAIL op_extra%0d: got we=%0b addr=%0d, want none",
                             obs_idx, o.we, o.addr);
                end else begin
                    e = exp_q.pop_front();
                    bad = (o.we !== e.we) || (o.addr !== e.addr) ||
                          (e.we && o.data !== e.data);
                    if (bad) begin
                        failed++;
                        $display("FAIL op%0d: got we=%0b addr=%0d data=%h, want we=%0b addr=%0d data=%h",
                                 obs_idx, o.we, o.addr, o.data,
                                 e.we, e.addr, e.data);
                    end
                end
                obs_idx++;
            end
        end
    end

    task automatic check_log(input int fa, input int fe);
`ifdef BIST_FAIL_LOG_EN
        check("fail_addr", 32'(fail_addr), fa);
        check("fail_elem", 32'(fail_elem), fe);
`else
        check("fail_addr", 32'(fail_addr), 0);
        check("fail_elem", 32'(fail_elem), 0);
        if (fa < 0 || fe < 0) $display("bad log args");
`endif
    endtask

    task automatic run_full(input bit hold, input int fail_cyc,
                            input bit exp_fail, input int fa, input int fe);
        push_ops(NOPS);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        check("busy_c0", 32'(busy), 1);
        check("en_c0", 32'(mem_en), 0);
        check("fail_clr", 32'(fail), 0);
        check_log(0, 0);
        for (int k = 1; k <= 162; k++) begin
            @(posedge clk);
            #1;
            if (k == 2 && !hold) start = 1'b0;
            if (k == 1) check("en_c1", 32'(mem_en), 1);
            if (fail_cyc > 0 && k == fail_cyc - 1)
                check("fail_pre", 32'(fail), 0);
            if (fail_cyc > 0 && k == fail_cyc)
                check("fail_rise", 32'(fail), 1);
            if (k == 161) begin
                check("drain_en", 32'(mem_en), 0);
                check("drain_busy", 32'(busy), 1);
                check("drain_done", 32'(done), 0);
            end
        end
        check("done_c162", 32'(done), 1);
        check("busy_c162", 32'(busy), 0);
        check("fail_end", 32'(fail), 32'(exp_fail));
        check_log(fa, fe);
        check("ops_left", exp_q.size(), 0);
        if (!hold) repeat (2) @(posedge clk);
    endtask

    initial begin
        rst   = 1'b0;
        start = 1'b0;
        #1;
        check("rst_en", 32'(mem_en), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_fail", 32'(fail), 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // fault-free run, then direction checks on E3/E4
        run_full(1'b0, 0, 1'b0, 0, 0);
        check("e3_first_we", 32'(obs[80].we), 0);
        check("e3_first_addr", 32'(obs[80].addr), 15);
        check("e4_last_we", 32'(obs[143].we), 1);
        check("e4_last_addr", 32'(obs[143].addr), 0);

        // bit 3 stuck-at-0 at address 5: first caught by E2 read
        sa_addr = 5;
        run_full(1'b0, 61, 1'b1, 5, 2);
        sa_addr = -1;

        // two read faults; only the first is logged
        cr_addr[0] = 2;  cr_lo[0] = 16;  cr_hi[0] = 47;
        cr_addr[1] = 9;  cr_lo[1] = 112; cr_hi[1] = 143;
        run_full(1'b1, 23, 1'b1, 2, 1);
        cr_addr[0] = -1;
        cr_addr[1] = -1;

        // start held high: stays in DONE
        repeat (5) @(posedge clk);
        #1;
        check("hold_done", 32'(done), 1);
        check("hold_en", 32'(mem_en), 0);
        start = 1'b0;
        @(posedge clk);
        #1;
        check("idle_done", 32'(done), 0);
        run_full(1'b0, 0, 1'b0, 0, 0);

        // reset mid-run at cycle 50
        cr_addr[0] = 2; cr_lo[0] = 16; cr_hi[0] = 47;
        push_ops(49);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 50; k++) begin
            @(posedge clk);
            #1;
            if (k == 2) start = 1'b0;
        end
        check("abort_pre_fail", 32'(fail), 1);
        rst = 1'b0;
        #1;
        check("abort_en", 32'(mem_en), 0);
        check("abort_we", 32'(mem_we), 0);
        check("abort_addr", 32'(mem_addr), 0);
        check("abort_wdata", 32'(mem_wdata), 0);
        check("abort_busy", 32'(busy), 0);
        check("abort_done", 32'(done), 0);
        check("abort_fail", 32'(fail), 0);
        check("abort_faddr", 32'(fail_addr), 0);
        check("abort_felem", 32'(fail_elem), 0);
        @(negedge clk);
        check("abort_ops_left", exp_q.size(), 0);
        cr_addr[0] = -1;
        @(negedge clk);
        rst = 1'b1;
        run_full(1'b0, 0, 1'b0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
